// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - opcode/format enums, field layout, immediate ranges, encode and range-check helpers
// Ports: none (package).
package inst_pkg;

   // Opcodes in the order the control unit decodes them; the gaps hold opcodes
   // the encoder never needs to name.
   typedef enum logic [6:0] {
      OP_HALT = 7'd0,
      OP_NOP  = 7'd1,
      OP_JMP  = 7'd2,
      OP_JAL  = 7'd3,
      OP_JMPR = 7'd4,
      OP_JALR = 7'd5,
      OP_BI   = 7'd6,
      OP_BR   = 7'd7,
      OP_LIH  = 7'd8,
      OP_LIL  = 7'd9,
      OP_LD32 = 7'd10,
      OP_ADDI = 7'd18,
      OP_ALU  = 7'd26
   } op_e;

   typedef enum logic [2:0] {
      FMT_N    = 3'd0,
      FMT_R    = 3'd1,
      FMT_I    = 3'd2,
      FMT_LI   = 3'd3,
      FMT_J    = 3'd4,
      FMT_LI32 = 3'd5
   } fmt_e;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_LI_HI = 1'b1
   } enc_state_e;

   localparam int OP_LSB   = 25;
   localparam int RD_LSB   = 20;
   localparam int RS1_LSB  = 15;
   localparam int RS2_LSB  = 10;
   localparam int FUNC_LSB = 0;

   localparam int IMM_I_MIN  = -16384;
   localparam int IMM_I_MAX  = 16383;
   localparam int IMM_J_MIN  = -(1 << 24);
   localparam int IMM_J_MAX  = (1 << 24) - 1;
   localparam int IMM_LI_MAX = 65535;

   function automatic logic imm_ok(input fmt_e fmt, input logic [31:0] imm);
      logic ok;
      ok = 1'b1;
      case (fmt)
         FMT_I:   ok = ($signed(imm) >= IMM_I_MIN) && ($signed(imm) <= IMM_I_MAX);
         FMT_J:   ok = ($signed(imm) >= IMM_J_MIN) && ($signed(imm) <= IMM_J_MAX);
         FMT_LI:  ok = (imm <= 32'(IMM_LI_MAX));
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   // Unknown format codes fall back to op-only so no stray field bits leak out.
   function automatic logic [31:0] encode(input logic [6:0] op, input fmt_e fmt,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [3:0] func,
                                          input logic [31:0] imm);
      logic [31:0] w;
      w = '0;
      w[OP_LSB +: 7] = op;
      case (fmt)
         FMT_R: begin
            w[RD_LSB +: 5]   = rd;
            w[RS1_LSB +: 5]  = rs1;
            w[RS2_LSB +: 5]  = rs2;
            w[FUNC_LSB +: 4] = func;
         end
         FMT_I: begin
            w[RD_LSB +: 5]  = rd;
            w[RS1_LSB +: 5] = rs1;
            w[14:0]         = imm[14:0];
         end
         FMT_LI: begin
            w[RD_LSB +: 5] = rd;
            w[15:0]        = imm[15:0];
         end
         FMT_J:   w[24:0] = imm[24:0];
         default: w = w;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - request and instruction-word stream bundle between loader, encoder and memory
// Ports: in_* request channel (valid/ready), out_* word channel (valid/ready) with write address.
// master = request source / word sink, slave = encoder.
interface inst_encoder_if #(
   parameter int ADDR_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_op;
   logic [2:0]        in_fmt;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [3:0]        in_func;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output in_valid, in_op, in_fmt, in_rd, in_rs1, in_rs2, in_func, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr
   );

   modport slave (
      input  in_valid, in_op, in_fmt, in_rd, in_rs1, in_rs2, in_func, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr
   );
endinterface

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - DEPTH-entry word FIFO used as the encoder output buffer
// Ports: clk, rst_n (async active-low); push/push_data write; pop advances head;
// head is the oldest entry; count is occupancy; empty flags count==0.
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   // Push into a full buffer is allowed only when a pop frees the slot that cycle.
   assign pop_ok  = pop && (count_q != '0);
   assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs operation requests into 32-bit instruction words streamed to instruction memory
// Ports: clk, rst_n (async active-low); bus (inst_encoder_if.slave) request and word streams;
// addr_load/addr_base reload the write-address counter; err one-cycle reject pulse;
// err_count saturating reject count; busy = expansion pending or buffer non-empty.
module inst_encoder
   import inst_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   inst_encoder_if.slave     bus,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_base,
   output logic              err,
   output logic [7:0]        err_count,
   output logic              busy
);
   localparam int CW = $clog2(DEPTH) + 1;

   enc_state_e        state_q, state_d;
   logic [15:0]       hi_q, hi_d;
   logic [4:0]        rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              push;
   logic [31:0]       push_data;
   logic              pop;
   logic [31:0]       head;
   logic [CW-1:0]     count;
   logic              empty;
   logic              in_ready_c;
   logic              accept;
   fmt_e              fmt;

   assign fmt = fmt_e'(bus.in_fmt);

   // Two free entries are reserved at accept so the lih of an li32 always fits.
   assign in_ready_c = (state_q == ST_IDLE) && (count <= CW'(DEPTH - 2));
   assign accept     = bus.in_valid && in_ready_c;
   assign pop        = !empty && bus.out_ready;

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      rd_d      = rd_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      push      = 1'b0;
      push_data = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (fmt == FMT_LI32) begin
                  push      = 1'b1;
                  push_data = encode(OP_LIL, FMT_LI, bus.in_rd, 5'd0, 5'd0, 4'd0,
                                     {16'd0, bus.in_imm[15:0]});
                  hi_d      = bus.in_imm[31:16];
                  rd_d      = bus.in_rd;
                  state_d   = ST_LI_HI;
               end else if (imm_ok(fmt, bus.in_imm)) begin
                  push      = 1'b1;
                  push_data = encode(bus.in_op, fmt, bus.in_rd, bus.in_rs1, bus.in_rs2,
                                     bus.in_func, bus.in_imm);
               end else begin
                  err_d = 1'b1;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end
            end
         end
         ST_LI_HI: begin
            push      = 1'b1;
            push_data = encode(OP_LIH, FMT_LI, rd_q, 5'd0, 5'd0, 4'd0, {16'd0, hi_q});
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A word handshaken alongside a load keeps its old address; the load wins.
   always_comb begin
      addr_d = addr_q;
      if (addr_load) begin
         addr_d = addr_base;
      end else if (pop) begin
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         hi_q      <= '0;
         rd_q      <= '0;
         addr_q    <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   inst_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(32)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .head     (head),
      .count    (count),
      .empty    (empty)
   );

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = !empty;
   assign bus.out_inst  = empty ? 32'd0 : head;
   assign bus.out_addr  = addr_q;
   assign err           = err_q;
   assign err_count     = err_cnt_q;
   assign busy          = (state_q != ST_IDLE) || !empty;
endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard bench for inst_encoder
module tb_inst_encoder;
   import inst_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        addr_load;
   logic [15:0] addr_base;
   logic        err;
   logic [7:0]  err_count;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   logic [15:0] model_addr = '0;

   inst_encoder_if #(.ADDR_W(16)) bus ();

   inst_encoder #(
      .ADDR_W(16),
      .DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .addr_load(addr_load),
      .addr_base(addr_base),
      .err      (err),
      .err_count(err_count),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [2:0] fmt,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [3:0] func,
                                           input logic [31:0] imm);
      logic [31:0] o;
      o = 32'(op) << 25;
      case (fmt)
         3'd1: o = o | (32'(rd) << 20) | (32'(rs1) << 15) | (32'(rs2) << 10) | 32'(func);
         3'd2: o = o | (32'(rd) << 20) | (32'(rs1) << 15) | (imm & 32'h0000_7FFF);
         3'd3: o = o | (32'(rd) << 20) | (imm & 32'h0000_FFFF);
         3'd4: o = o | (imm & 32'h01FF_FFFF);
         default: o = o;
      endcase
      return o;
   endfunction

   function automatic bit ref_legal(input logic [2:0] fmt, input logic [31:0] imm);
      int s;
      s = int'($signed(imm));
      case (fmt)
         3'd2:    return (s >= -16384) && (s <= 16383);
         3'd4:    return (s >= -16777216) && (s <= 16777215);
         3'd3:    return imm < 32'd65536;
         default: return 1'b1;
      endcase
   endfunction

   // Scoreboard monitor: compares every handshaken word and its address.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_addr = '0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               check("word", bus.out_inst, exp_q.pop_front());
               check("addr", {16'd0, bus.out_addr}, {16'd0, model_addr});
            end
         end
         if (addr_load) model_addr = addr_base;
         else if (bus.out_valid && bus.out_ready) model_addr = model_addr + 16'd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is aligned 1 time unit after a rising edge; returns aligned the same way
   // just after the accepting edge.
   task automatic send(input logic [6:0] op, input logic [2:0] fmt, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [3:0] func,
                       input logic [31:0] imm, input bit push_exp);
      int w;
      bit ok;
      w  = 0;
      ok = 1'b0;
      bus.in_op   = op;
      bus.in_fmt  = fmt;
      bus.in_rd   = rd;
      bus.in_rs1  = rs1;
      bus.in_rs2  = rs2;
      bus.in_func = func;
      bus.in_imm  = imm;
      bus.in_valid = 1'b1;
      while (!ok && w < 50) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         else w++;
         if (!ok) tick();
      end
      if (!ok) begin
         check("send_timeout", 32'(w), 32'd0);
         bus.in_valid = 1'b0;
         tick();
         return;
      end
      if (push_exp) begin
         if (fmt == 3'd5) begin
            exp_q.push_back(ref_enc(7'd9, 3'd3, rd, 5'd0, 5'd0, 4'd0, imm & 32'h0000_FFFF));
            exp_q.push_back(ref_enc(7'd8, 3'd3, rd, 5'd0, 5'd0, 4'd0, imm >> 16));
         end else if (ref_legal(fmt, imm)) begin
            exp_q.push_back(ref_enc(op, fmt, rd, rs1, rs2, func, imm));
         end
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || busy) && w < 200) begin
         tick();
         w++;
      end
      check("drain_timeout", 32'(w >= 200), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] first_word;
      rst_n        = 1'b0;
      addr_load    = 1'b0;
      addr_base    = '0;
      bus.in_valid = 1'b0;
      bus.in_op    = '0;
      bus.in_fmt   = '0;
      bus.in_rd    = '0;
      bus.in_rs1   = '0;
      bus.in_rs2   = '0;
      bus.in_func  = '0;
      bus.in_imm   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_inst", bus.out_inst, 32'd0);
      check("rst_out_addr", {16'd0, bus.out_addr}, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);

      // addi with one-cycle latency
      bus.out_ready = 1'b1;
      send(7'd18, 3'd2, 5'd3, 5'd1, 5'd0, 4'd0, 32'd5, 1'b1);
      @(negedge clk);
      check("lat_valid", 32'(bus.out_valid), 32'd1);
      check("lat_inst", bus.out_inst, 32'h2430_8005);
      check("lat_addr", {16'd0, bus.out_addr}, 32'd0);
      tick();

      // R-format alu
      send(7'd26, 3'd1, 5'd4, 5'd5, 5'd6, 4'd2, 32'd0, 1'b1);
      @(negedge clk);
      check("alu_inst", bus.out_inst, 32'h3442_9802);
      tick();
      wait_drain();

      // li32 expansion
      send(7'd0, 3'd5, 5'd2, 5'd0, 5'd0, 4'd0, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      check("li_hi_in_ready", 32'(bus.in_ready), 32'd0);
      check("li_lo_inst", bus.out_inst, 32'h1220_BEEF);
      tick();
      @(negedge clk);
      check("li_hi_inst", bus.out_inst, 32'h1020_DEAD);
      tick();
      wait_drain();

      // out-of-range immediate then jmp
      send(7'd18, 3'd2, 5'd3, 5'd1, 5'd0, 4'd0, 32'd16384, 1'b1);
      @(negedge clk);
      check("err_pulse", 32'(err), 32'd1);
      check("err_count_1", 32'(err_count), 32'd1);
      check("err_no_word", 32'(bus.out_valid), 32'd0);
      tick();
      @(negedge clk);
      check("err_clear", 32'(err), 32'd0);
      tick();
      send(7'd2, 3'd4, 5'd0, 5'd0, 5'd0, 4'd0, -32'sd4, 1'b1);
      @(negedge clk);
      check("jmp_inst", bus.out_inst, 32'h05FF_FFFC);
      tick();
      send(7'd2, 3'd4, 5'd0, 5'd0, 5'd0, 4'd0, 32'h0100_0000, 1'b1);
      send(7'd9, 3'd3, 5'd7, 5'd0, 5'd0, 4'd0, 32'h0001_0000, 1'b1);
      @(negedge clk);
      check("err_count_3", 32'(err_count), 32'd3);
      tick();
      send(7'd9, 3'd3, 5'd7, 5'd0, 5'd0, 4'd0, 32'h0000_FFFF, 1'b1);
      wait_drain();

      // backpressure
      addr_load = 1'b1;
      addr_base = 16'h0000;
      tick();
      addr_load = 1'b0;
      bus.out_ready = 1'b0;
      first_word = ref_enc(7'd18, 3'd2, 5'd1, 5'd2, 5'd0, 4'd0, 32'd100);
      for (int i = 1; i <= 3; i++) begin
         send(7'd18, 3'd2, 5'(i), 5'd2, 5'd0, 4'd0, 32'(i * 100), 1'b1);
      end
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_head", bus.out_inst, first_word);
      repeat (3) tick();
      @(negedge clk);
      check("bp_stable", bus.out_inst, first_word);
      check("bp_addr", {16'd0, bus.out_addr}, 32'd0);
      tick();
      bus.out_ready = 1'b1;
      wait_drain();

      // address load during a handshake
      bus.out_ready = 1'b0;
      send(7'd26, 3'd1, 5'd1, 5'd2, 5'd3, 4'd4, 32'd0, 1'b1);
      send(7'd26, 3'd1, 5'd5, 5'd6, 5'd7, 4'd8, 32'd0, 1'b1);
      bus.out_ready = 1'b1;
      addr_load = 1'b1;
      addr_base = 16'h0100;
      tick();
      addr_load = 1'b0;
      wait_drain();
      check("load_final_addr", {16'd0, bus.out_addr}, 32'h0000_0101);

      // counter wrap
      addr_load = 1'b1;
      addr_base = 16'hFFFF;
      tick();
      addr_load = 1'b0;
      send(7'd1, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0, 32'd0, 1'b1);
      send(7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 4'd0, 32'd0, 1'b1);
      wait_drain();
      check("wrap_addr", {16'd0, bus.out_addr}, 32'd1);

      // reset during the lih cycle
      send(7'd0, 3'd5, 5'd9, 5'd0, 5'd0, 4'd0, 32'h1234_5678, 1'b0);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_no_lih", 32'(bus.out_valid), 32'd0);
         tick();
      end
      send(7'd18, 3'd2, 5'd1, 5'd1, 5'd0, 4'd0, -32'sd16384, 1'b1);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
